// File: rtl/adc_sample_conditioner.sv
// Block-averages 2^LOG2_AVG ADC samples, widens to 14 bits, applies Q8.8 gain and offset, saturates to DAC range.
// One result per block; output held until the downstream handshake, input blocked outside ACCUM.
module adc_sample_conditioner #(
  parameter int unsigned LOG2_AVG = 2,
  parameter int unsigned GAIN_Q8  = 256,
  parameter int          OFFSET   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [11:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [13:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        sat_sticky
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CALC  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam logic [4:0]         CNT_LAST = 5'((1 << LOG2_AVG) - 1);
  localparam logic [29:0]        GAIN_W   = 30'(GAIN_Q8 & 32'h0000_FFFF);
  localparam logic signed [23:0] OFF_S    = 24'(OFFSET);
  localparam logic signed [23:0] DAC_MAX  = 24'sd16383;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] mean_q, mean_d;
  logic [21:0] prod_q, prod_d;
  logic [13:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        sat_q, sat_d;

  logic               s_hs;
  logic [15:0]        sum;
  logic [29:0]        mult;
  logic signed [23:0] sum_s;
  logic               under, over;
  logic [13:0]        sat_val;

  // Input is refused during clr so a sample cannot be lost to the accumulator wipe.
  assign s_axis_tready = ~rst & ~clr & (state_q == ST_ACCUM);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign sat_sticky    = sat_q;

  always_comb begin
    s_hs    = s_axis_tvalid & s_axis_tready;
    sum     = acc_q + {4'd0, s_axis_tdata};
    mult    = 30'({mean_q, 2'b00}) * GAIN_W;
    sum_s   = $signed({2'b00, prod_q}) + OFF_S;
    under   = sum_s[23];
    over    = !under && (sum_s > DAC_MAX);
    sat_val = under ? 14'd0 : (over ? 14'h3FFF : sum_s[13:0]);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mean_d   = mean_q;
    prod_d   = prod_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    sat_d    = sat_q;

    case (state_q)
      ST_ACCUM: begin
        if (clr) begin
          acc_d = 16'd0;
          cnt_d = 5'd0;
        end else if (s_hs) begin
          if (cnt_q == CNT_LAST) begin
            mean_d  = 12'(sum >> LOG2_AVG);
            acc_d   = 16'd0;
            cnt_d   = 5'd0;
            state_d = ST_CALC;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_CALC: begin
        prod_d  = 22'(mult >> 8);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        // First OUT cycle loads the result; later cycles wait for the DAC.
        if (!tvalid_q) begin
          tdata_d  = sat_val;
          tvalid_d = 1'b1;
          if (under || over) sat_d = 1'b1;
        end else if (m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    if (clr) sat_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACCUM;
      acc_q    <= 16'd0;
      cnt_q    <= 5'd0;
      mean_q   <= 12'd0;
      prod_q   <= 22'd0;
      tdata_q  <= 14'd0;
      tvalid_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mean_q   <= mean_d;
      prod_q   <= prod_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench: four conditioner instances with different parameter sets share clock, rst and clr.
// Instance 0: avg 1, gain 1.0; 1: avg 4; 2: avg 4, gain 2.0; 3: avg 1, offset -100.
module tb_adc_sample_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] s_dat [4];
  logic        s_vld [4];
  logic        s_rdy [4];
  logic [13:0] m_dat [4];
  logic        m_vld [4];
  logic        m_rdy [4];
  logic        sat   [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_sample_conditioner #(.LOG2_AVG(0), .GAIN_Q8(256), .OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_tdata(s_dat[0]), .s_axis_tvalid(s_vld[0]), .s_axis_tready(s_rdy[0]),
    .m_axis_tdata(m_dat[0]), .m_axis_tvalid(m_vld[0]), .m_axis_tready(m_rdy[0]),
    .sat_sticky(sat[0]));

  adc_sample_conditioner #(.LOG2_AVG(2), .GAIN_Q8(256), .OFFSET(0)) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_tdata(s_dat[1]), .s_axis_tvalid(s_vld[1]), .s_axis_tready(s_rdy[1]),
    .m_axis_tdata(m_dat[1]), .m_axis_tvalid(m_vld[1]), .m_axis_tready(m_rdy[1]),
    .sat_sticky(sat[1]));

  adc_sample_conditioner #(.LOG2_AVG(2), .GAIN_Q8(512), .OFFSET(0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_tdata(s_dat[2]), .s_axis_tvalid(s_vld[2]), .s_axis_tready(s_rdy[2]),
    .m_axis_tdata(m_dat[2]), .m_axis_tvalid(m_vld[2]), .m_axis_tready(m_rdy[2]),
    .sat_sticky(sat[2]));

  adc_sample_conditioner #(.LOG2_AVG(0), .GAIN_Q8(256), .OFFSET(-100)) dut3 (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_tdata(s_dat[3]), .s_axis_tvalid(s_vld[3]), .s_axis_tready(s_rdy[3]),
    .m_axis_tdata(m_dat[3]), .m_axis_tvalid(m_vld[3]), .m_axis_tready(m_rdy[3]),
    .sat_sticky(sat[3]));

  // Returns #1 after the handshake edge.
  task automatic send(input int k, input logic [11:0] d, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    @(negedge clk);
    s_dat[k] = d;
    s_vld[k] = 1'b1;
    while (!s_rdy[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy[k]) ok = 1'b0;
    else begin
      @(posedge clk);
      #1;
    end
    s_vld[k] = 1'b0;
  endtask

  task automatic collect(input int k, output logic [13:0] d, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    d  = '0;
    @(negedge clk);
    while (!m_vld[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_vld[k]) ok = 1'b0;
    else begin
      d = m_dat[k];
      m_rdy[k] = 1'b1;
      @(posedge clk);
      #1;
      m_rdy[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 4; k++) begin
      s_dat[k] = '0;
      s_vld[k] = 1'b0;
      m_rdy[k] = 1'b0;
    end
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (s_rdy[k] !== 1'b0) begin bad++; $display("FAIL reset_s_rdy[%0d]: got %b want 0", k, s_rdy[k]); end
      total++;
      if (m_vld[k] !== 1'b0) begin bad++; $display("FAIL reset_m_vld[%0d]: got %b want 0", k, m_vld[k]); end
      total++;
      if (m_dat[k] !== 14'd0) begin bad++; $display("FAIL reset_m_dat[%0d]: got %0d want 0", k, m_dat[k]); end
      total++;
      if (sat[k] !== 1'b0) begin bad++; $display("FAIL reset_sat[%0d]: got %b want 0", k, sat[k]); end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_rdy[0] !== 1'b1) begin bad++; $display("FAIL post_reset_s_rdy: got %b want 1", s_rdy[0]); end
  endtask

  task automatic test_passthrough;
    bit ok;
    send(0, 12'hABC, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL pass_send: got timeout want handshake"); end
    @(negedge clk);
    total++;
    if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL pass_lat_n0: got %b want 0", m_vld[0]); end
    @(negedge clk);
    total++;
    if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL pass_lat_n1: got %b want 0", m_vld[0]); end
    @(negedge clk);
    total++;
    if (m_vld[0] !== 1'b1) begin bad++; $display("FAIL pass_lat_n2: got %b want 1", m_vld[0]); end
    total++;
    if (m_dat[0] !== 14'h2AF0) begin bad++; $display("FAIL pass_data: got %h want 2af0", m_dat[0]); end
    total++;
    if (s_rdy[0] !== 1'b0) begin bad++; $display("FAIL pass_in_blocked: got %b want 0", s_rdy[0]); end
    m_rdy[0] = 1'b1;
    @(posedge clk);
    #1 m_rdy[0] = 1'b0;
    @(negedge clk);
    total++;
    if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL pass_vld_drop: got %b want 0", m_vld[0]); end
    total++;
    if (s_rdy[0] !== 1'b1) begin bad++; $display("FAIL pass_rdy_back: got %b want 1", s_rdy[0]); end
  endtask

  task automatic test_average;
    bit ok;
    logic [13:0] d;
    send(1, 12'd100, ok);
    send(1, 12'd200, ok);
    send(1, 12'd300, ok);
    repeat (6) @(negedge clk);
    total++;
    if (m_vld[1] !== 1'b0) begin bad++; $display("FAIL avg_partial_vld: got %b want 0", m_vld[1]); end
    total++;
    if (s_rdy[1] !== 1'b1) begin bad++; $display("FAIL avg_partial_rdy: got %b want 1", s_rdy[1]); end
    send(1, 12'd401, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL avg_send: got timeout want handshake"); end
    collect(1, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 14'd1000) begin bad++; $display("FAIL avg_out: got %0d (ok=%0b) want 1000", d, ok); end
    total++;
    if (sat[1] !== 1'b0) begin bad++; $display("FAIL avg_sat: got %b want 0", sat[1]); end
  endtask

  task automatic test_saturate;
    bit ok;
    logic [13:0] d;
    for (int i = 0; i < 4; i++) send(2, 12'hFFF, ok);
    collect(2, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 14'd16383) begin bad++; $display("FAIL sat_out: got %0d (ok=%0b) want 16383", d, ok); end
    total++;
    if (sat[2] !== 1'b1) begin bad++; $display("FAIL sat_sticky_set: got %b want 1", sat[2]); end
    @(negedge clk);
    clr = 1'b1;
    #1;
    total++;
    if (s_rdy[2] !== 1'b0) begin bad++; $display("FAIL clr_blocks_input: got %b want 0", s_rdy[2]); end
    @(posedge clk);
    #1 clr = 1'b0;
    total++;
    if (sat[2] !== 1'b0) begin bad++; $display("FAIL clr_sticky: got %b want 0", sat[2]); end
  endtask

  task automatic test_offset;
    bit ok;
    logic [13:0] d;
    send(3, 12'd10, ok);
    collect(3, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 14'd0) begin bad++; $display("FAIL off_neg_clamp: got %0d (ok=%0b) want 0", d, ok); end
    total++;
    if (sat[3] !== 1'b1) begin bad++; $display("FAIL off_sticky: got %b want 1", sat[3]); end
    send(3, 12'd100, ok);
    collect(3, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 14'd300) begin bad++; $display("FAIL off_normal: got %0d (ok=%0b) want 300", d, ok); end
    total++;
    if (sat[3] !== 1'b1) begin bad++; $display("FAIL off_sticky_hold: got %b want 1", sat[3]); end
  endtask

  task automatic test_stall;
    bit ok;
    int n;
    logic [13:0] d;
    send(0, 12'd291, ok);
    n = 0;
    while (!m_vld[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Offer a competing sample during the stall; it must not be taken.
    s_dat[0] = 12'd7;
    s_vld[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (m_vld[0] !== 1'b1 || m_dat[0] !== 14'd1164 || s_rdy[0] !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got vld=%b dat=%0d rdy=%b want vld=1 dat=1164 rdy=0",
                 i, m_vld[0], m_dat[0], s_rdy[0]);
      end
    end
    collect(0, d, ok);
    s_vld[0] = 1'b0;
    total++;
    if (ok !== 1'b1 || d !== 14'd1164) begin bad++; $display("FAIL stall_release: got %0d (ok=%0b) want 1164", d, ok); end
    repeat (4) @(negedge clk);
    total++;
    if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL stall_no_extra: got %b want 0", m_vld[0]); end
  endtask

  task automatic test_reset_midblock;
    bit ok;
    int n;
    logic [13:0] d;
    send(1, 12'd3000, ok);
    send(1, 12'd3000, ok);
    send(0, 12'd5, ok);
    n = 0;
    while (!m_vld[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (m_vld[0] !== 1'b1) begin bad++; $display("FAIL rst_pending_setup: got %b want 1", m_vld[0]); end
    rst = 1'b1;
    #1;
    total++;
    if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL rst_async_vld: got %b want 0", m_vld[0]); end
    total++;
    if (s_rdy[1] !== 1'b0) begin bad++; $display("FAIL rst_s_rdy: got %b want 0", s_rdy[1]); end
    @(negedge clk);
    rst = 1'b0;
    send(1, 12'd1000, ok);
    send(1, 12'd1000, ok);
    repeat (5) @(negedge clk);
    total++;
    if (m_vld[1] !== 1'b0) begin bad++; $display("FAIL rst_stale_partial: got vld=%b want 0", m_vld[1]); end
    send(1, 12'd1000, ok);
    send(1, 12'd1000, ok);
    collect(1, d, ok);
    total++;
    if (ok !== 1'b1 || d !== 14'd4000) begin bad++; $display("FAIL rst_fresh_block: got %0d (ok=%0b) want 4000", d, ok); end
    total++;
    if (m_vld[0] !== 1'b0) begin bad++; $display("FAIL rst_dropped_out: got %b want 0", m_vld[0]); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_average();
    test_saturate();
    test_offset();
    test_stall();
    test_reset_midblock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
